// File: rtl/rd_steer_pkg.sv
// Shared types and default sizing for the capture-buffer read-side controller.
package rd_steer_pkg;

    // Default geometry: 2048 x 8-bit capture buffer unloaded across 8 lanes.
    localparam int DEPTH_DEF = 2048;
    localparam int AW_DEF    = 11;
    localparam int DW_DEF    = 8;
    localparam int LANES_DEF = 8;
    localparam int SW_DEF    = 3;

    // Lane select value held while no pass has been started.
    localparam logic [SW_DEF-1:0] SEL_RESET = 3'b111;

    // Controller phases; the encoding is also visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/rd_skid2.sv
// Two-entry skid FIFO with flow-through: a word pushed into an empty FIFO is
// presented at the head in the same cycle, so a ready consumer sees no extra
// latency. Contents are discarded by flush.
module rd_skid2 #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_data_o,
    output logic          head_valid_o,
    output logic [1:0]    count_o,
    output logic          empty_o
);

    logic [DW-1:0] e0_q;
    logic [DW-1:0] e1_q;
    logic [1:0]    cnt_q;
    logic          store;
    logic          deq;
    logic [1:0]    slot;

    assign empty_o      = (cnt_q == 2'd0);
    assign count_o      = cnt_q;
    assign head_valid_o = !empty_o || push_i;
    assign head_data_o  = !empty_o ? e0_q : (push_i ? push_data_i : '0);

    // A push that is consumed straight through the bypass never occupies a slot.
    assign store = push_i && !(empty_o && pop_i);
    assign deq   = pop_i && !empty_o;
    assign slot  = cnt_q - {1'b0, deq};

    // Shift-register storage: entry 0 is always the head.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            if (deq) e0_q <= e1_q;
            if (store && slot == 2'd0) e0_q <= push_data_i;
            if (store && slot == 2'd1) e1_q <= push_data_i;
            cnt_q <= cnt_q + {1'b0, store} - {1'b0, deq};
        end
    end

    // The issuer's credit accounting must never let a third word arrive.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (flush_i)
        !(cnt_q == 2'd2 && push_i && !pop_i));

    // Nothing may be popped when nothing is presented.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (flush_i)
        !(pop_i && !head_valid_o));

endmodule

// File: rtl/rd_steer_ctrl.sv
// Read-side unload controller: once the writer reports the buffer full, sweep
// port-B addresses 0..DEPTH-1 and steer each returned word round-robin across
// the output lanes. Handshake: a word moves when lane_valid && lane_ready at a
// rising edge; lane_valid never drops and lane_data/selectline never change
// while a presented word waits for lane_ready.
module rd_steer_ctrl
    import rd_steer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int LANES = LANES_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic          readclk,
    input  logic          reset,
    input  logic          start,
    input  logic          lock,
    input  logic          full,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] doutb,
    output logic [DW-1:0] lane_data,
    output logic [SW-1:0] selectline,
    output logic          lane_valid,
    input  logic          lane_ready,
    output logic          ensteer,
    output logic          complete,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] SEL_INIT  = {SW{SEL_RESET[0]}};

    state_e        state_q, state_d;
    logic          enb_q, enb_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   issue_q, issue_d;
    logic [AW:0]   out_q, out_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          rvalid_q;

    logic [DW-1:0] head_data;
    logic          head_valid;
    logic [1:0]    skid_count;
    logic          skid_empty;
    logic          xfer;
    logic [2:0]    pending;
    logic          credit_ok;

    rd_skid2 #(.DW(DW)) u_skid (
        .clk_i        (readclk),
        .flush_i      (reset),
        .push_i       (rvalid_q),
        .push_data_i  (doutb),
        .pop_i        (xfer),
        .head_data_o  (head_data),
        .head_valid_o (head_valid),
        .count_o      (skid_count),
        .empty_o      (skid_empty)
    );

    assign xfer = head_valid && lane_ready;

    // Words that will still need a skid slot: the read on the RAM port, the
    // response returning now and the stored words, less the word leaving now.
    // Issuing only while this is below 2 keeps the skid from overflowing and
    // still sustains one word per cycle when lane_ready stays high.
    assign pending   = 3'(enb_q) + 3'(rvalid_q) + 3'(skid_count) - 3'(xfer);
    assign credit_ok = (pending < 3'd2);

    // Next-state: FSM transitions, read issue and lane steering.
    always_comb begin
        state_d = state_q;
        enb_d   = 1'b0;
        addr_d  = addr_q;
        issue_d = issue_q;
        out_d   = out_q;
        sel_d   = sel_q;
        if (xfer) begin
            out_d = out_q + (AW+1)'(1);
            sel_d = sel_q + SW'(1);
        end
        case (state_q)
            IDLE: begin
                if (start && lock && full) begin
                    state_d = STREAM;
                    addr_d  = '0;
                    issue_d = '0;
                    out_d   = '0;
                    sel_d   = '0;
                end
            end
            STREAM: begin
                if (issue_q == DEPTH_CNT) begin
                    state_d = DRAIN;
                end else if (lock && credit_ok) begin
                    enb_d   = 1'b1;
                    addr_d  = issue_q[AW-1:0];
                    issue_d = issue_q + (AW+1)'(1);
                end
            end
            DRAIN: begin
                if (out_d == DEPTH_CNT) state_d = DONE;
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; a RAM response already in flight at reset is dropped.
    always_ff @(posedge readclk) begin
        if (reset) begin
            state_q  <= IDLE;
            enb_q    <= 1'b0;
            addr_q   <= '0;
            issue_q  <= '0;
            out_q    <= '0;
            sel_q    <= SEL_INIT;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            enb_q    <= enb_d;
            addr_q   <= addr_d;
            issue_q  <= issue_d;
            out_q    <= out_d;
            sel_q    <= sel_d;
            rvalid_q <= enb_q;
        end
    end

    assign enb        = enb_q;
    assign addrb      = addr_q;
    assign lane_data  = head_data;
    assign lane_valid = head_valid;
    assign selectline = sel_q;
    assign ensteer    = (state_q == STREAM) || (state_q == DRAIN);
    assign busy       = (state_q == STREAM) || (state_q == DRAIN);
    assign complete   = (state_q == DONE);
    assign state_dbg  = state_q;

    // Between passes nothing may be left waiting in the skid.
    a_idle_empty: assert property (@(posedge readclk) disable iff (reset)
        (state_q == IDLE) |-> skid_empty);

endmodule

// File: tb/tb_rd_steer_ctrl.sv
// Bench for rd_steer_ctrl on a 16-word buffer: a behavioural RAM, a word
// scoreboard built from the RAM image, and directed passes with random data
// and random lane_ready.
module tb_rd_steer_ctrl;
    import rd_steer_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int LANES = 8;
    localparam int SW    = 3;

    logic          readclk = 1'b0;
    logic          reset, start, lock, full;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb = '0;
    logic [DW-1:0] lane_data;
    logic [SW-1:0] selectline;
    logic          lane_valid;
    logic          lane_ready;
    logic          ensteer, complete, busy;
    logic [1:0]    state_dbg;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            exp_addr, enb_cnt, xfer_cnt;
    int            ready_pct;
    bit            in_pass;
    bit            stall_prev;
    logic [DW-1:0] data_prev;
    logic [SW-1:0] sel_prev;

    rd_steer_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .LANES(LANES), .SW(SW)) dut (
        .readclk    (readclk),
        .reset      (reset),
        .start      (start),
        .lock       (lock),
        .full       (full),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb),
        .lane_data  (lane_data),
        .selectline (selectline),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .ensteer    (ensteer),
        .complete   (complete),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 readclk = ~readclk;

    // Synchronous-read RAM, port B
    always @(posedge readclk) begin
        if (enb) doutb <= mem[addrb];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive lane_ready after the edge, then score at the falling edge.
    task automatic step();
        logic lk;
        @(posedge readclk);
        lk = lock;
        #1;
        lane_ready = ($urandom_range(0, 99) < ready_pct);
        @(negedge readclk);
        if (!in_pass) begin
            check("idle_enb", 32'(enb), 0);
            check("idle_valid", 32'(lane_valid), 0);
            stall_prev = 1'b0;
            exp_addr = 0;
            enb_cnt = 0;
            xfer_cnt = 0;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
        end else begin
            if (!lk) check("enb_while_unlocked", 32'(enb), 0);
            if (enb) begin
                check("enb_addr", 32'(addrb), 32'(exp_addr));
                exp_addr++;
                enb_cnt++;
            end
            if (stall_prev) begin
                check("stall_valid", 32'(lane_valid), 1);
                check("stall_data", 32'(lane_data), 32'(data_prev));
                check("stall_sel", 32'(selectline), 32'(sel_prev));
            end
            if (lane_valid && lane_ready) begin
                if (exp_q.size() > 0) check("word", 32'(lane_data), 32'(exp_q.pop_front()));
                else check("extra_word", 32'(lane_valid), 0);
                check("lane", 32'(selectline), 32'(xfer_cnt % LANES));
                xfer_cnt++;
            end
            stall_prev = lane_valid && !lane_ready;
            data_prev  = lane_data;
            sel_prev   = selectline;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enb"}, 32'(enb), 0);
        check({tag, "_addrb"}, 32'(addrb), 0);
        check({tag, "_valid"}, 32'(lane_valid), 0);
        check({tag, "_data"}, 32'(lane_data), 0);
        check({tag, "_sel"}, 32'(selectline), 32'(SEL_RESET));
        check({tag, "_ensteer"}, 32'(ensteer), 0);
        check({tag, "_complete"}, 32'(complete), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    task automatic load_mem(input bit random_data);
        for (int i = 0; i < DEPTH; i++) mem[i] = random_data ? DW'($urandom_range(0, 255)) : DW'(i);
    endtask

    // Start a pass; with timed=1 (lane_ready held high) check the exact latencies.
    task automatic launch(input bit timed);
        step();
        step();
        in_pass = 1'b1;
        start = 1'b1;
        lock = 1'b1;
        full = 1'b1;
        if (timed) begin
            for (int cyc = 0; cyc < 20; cyc++) begin
                step();
                case (cyc)
                    0: begin
                        check("c0_enb", 32'(enb), 0);
                        check("c0_valid", 32'(lane_valid), 0);
                        check("c0_busy", 32'(busy), 1);
                        check("c0_ensteer", 32'(ensteer), 1);
                    end
                    1: begin
                        check("c1_enb", 32'(enb), 1);
                        check("c1_addrb", 32'(addrb), 0);
                        check("c1_valid", 32'(lane_valid), 0);
                    end
                    2: begin
                        check("c2_valid", 32'(lane_valid), 1);
                        check("c2_data", 32'(lane_data), 32'(mem[0]));
                        check("c2_sel", 32'(selectline), 0);
                    end
                    17: check("c17_complete", 32'(complete), 0);
                    18: check("c18_complete", 32'(complete), 1);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (complete) break;
            step();
        end
        check("complete_seen", 32'(complete), 1);
        check("enb_pulses", 32'(enb_cnt), DEPTH);
        check("words_delivered", 32'(xfer_cnt), DEPTH);
        check("words_left", 32'(exp_q.size()), 0);
        check("done_state", 32'(state_dbg), 32'(DONE));
        check("done_busy", 32'(busy), 0);
        check("done_ensteer", 32'(ensteer), 0);
        check("done_enb", 32'(enb), 0);
    endtask

    task automatic end_pass();
        step();
        check("done_hold", 32'(complete), 1);
        start = 1'b0;
        step();
        check("idle_complete", 32'(complete), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_state", 32'(state_dbg), 32'(IDLE));
        in_pass = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        lock = 1'b0;
        full = 1'b0;
        lane_ready = 1'b1;
        ready_pct = 100;
        in_pass = 1'b0;
        stall_prev = 1'b0;
        load_mem(1'b0);

        // Power-on reset
        repeat (3) step();
        check_reset_outputs("por");
        reset = 1'b0;
        step();
        check_reset_outputs("por_rel");

        // Full pass, data = address, lane_ready high, exact timing
        load_mem(1'b0);
        ready_pct = 100;
        launch(1'b1);
        wait_done(40);
        end_pass();

        // Backpressure: random data, lane_ready about 30% high
        load_mem(1'b1);
        ready_pct = 30;
        launch(1'b0);
        wait_done(400);
        end_pass();

        // lock dropped for 5 cycles after the 6th read
        load_mem(1'b0);
        ready_pct = 100;
        launch(1'b0);
        for (int i = 0; i < 50; i++) begin
            if (enb_cnt >= 6) break;
            step();
        end
        check("six_reads_seen", 32'(enb_cnt), 6);
        lock = 1'b0;
        repeat (5) step();
        check("enb_during_drop", 32'(enb_cnt), 6);
        lock = 1'b1;
        wait_done(60);
        end_pass();

        // Reset at the 9th transfer, then a fresh pass
        load_mem(1'b1);
        ready_pct = 100;
        launch(1'b0);
        for (int i = 0; i < 50; i++) begin
            if (xfer_cnt >= 9) break;
            step();
        end
        check("nine_words_seen", 32'(xfer_cnt), 9);
        reset = 1'b1;
        start = 1'b0;
        in_pass = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs("mid_rst");
        end
        reset = 1'b0;
        step();
        step();
        check_reset_outputs("mid_rel");
        load_mem(1'b1);
        ready_pct = 60;
        launch(1'b0);
        wait_done(200);
        end_pass();

        // full low: no reads while start and lock are high
        start = 1'b1;
        lock = 1'b1;
        full = 1'b0;
        repeat (50) step();
        check("nofull_busy", 32'(busy), 0);
        check("nofull_state", 32'(state_dbg), 32'(IDLE));
        load_mem(1'b0);
        ready_pct = 100;
        launch(1'b1);
        wait_done(40);
        end_pass();

        // Second pass over the same image must repeat the first exactly
        launch(1'b1);
        wait_done(40);
        end_pass();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
